// File: rtl/hv_cmd_scheduler.sv
// HV command scheduler: latches slow-control HV requests, launches one preparer frame at a time,
// then waits for the byte count, UART drain and guard gap. Optional watchdog: HV_TIMEOUT_EN.
module hv_cmd_scheduler #(
    parameter logic [15:0] GAP_CYCLES     = 16'd50000,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
) (
    input  logic        Clk_In,
    input  logic        Rst_N,
    input  logic        Req_Cfg,
    input  logic [55:0] Req_Hv_7Byte,
    input  logic        Req_On,
    input  logic        Req_Off,
    input  logic        Clr_Err,
    output logic        Prep_Start_Cfg,
    output logic        Prep_Start_Stop_Hv,
    output logic        Prep_Flag_Start,
    output logic [55:0] Prep_Hv_7Byte,
    input  logic        Prep_Out_En,
    input  logic        Tx_Busy,
    output logic        Busy,
    output logic        Done,
    output logic        Err_Timeout,
    output logic        Hv_Is_On
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_LAUNCH = 3'd2;
    localparam logic [2:0] ST_COUNT  = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_GAP    = 3'd5;

    localparam logic [1:0] KIND_CFG = 2'd0;
    localparam logic [1:0] KIND_ON  = 2'd1;
    localparam logic [1:0] KIND_OFF = 2'd2;

    localparam logic [55:0] HV_RESET = 56'h30_30_30_30_30_30_30;

    logic [2:0]  state_q, state_d;
    logic [1:0]  kind_q, kind_d;
    logic        pend_cfg_q, pend_cfg_d, pend_on_q, pend_on_d, pend_off_q, pend_off_d;
    logic [55:0] pend_hv_q, pend_hv_d;
    logic [55:0] prep_hv_q, prep_hv_d;
    logic        flag_start_q, flag_start_d;
    logic [3:0]  exp_cnt_q, exp_cnt_d;
    logic [3:0]  byte_cnt_q, byte_cnt_d;
    logic        step_q, step_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic        done_q, done_d;
    logic        hv_is_on_q, hv_is_on_d;
    logic        aborted;
    logic        in_idle, grant_off, grant_cfg, grant_on;

    // Requests are single-cycle pulses with no back-pressure; Prep_Out_En is a one-cycle byte strobe.
    assign in_idle   = (state_q == ST_IDLE);
    assign grant_off = in_idle & pend_off_q;
    assign grant_cfg = in_idle & ~pend_off_q & pend_cfg_q;
    assign grant_on  = in_idle & ~pend_off_q & ~pend_cfg_q & pend_on_q;

`ifdef HV_TIMEOUT_EN
    logic [23:0] wd_q, wd_d;
    logic        err_q, err_d;
    logic        abort_q, abort_d;
    assign aborted     = abort_q;
    assign Err_Timeout = err_q;
`else
    logic unused_clr_err;
    assign unused_clr_err = Clr_Err;
    assign aborted        = 1'b0;
    assign Err_Timeout    = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        prep_hv_d    = prep_hv_q;
        flag_start_d = flag_start_q;
        exp_cnt_d    = exp_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        step_d       = step_q;
        gap_cnt_d    = gap_cnt_q;
        done_d       = 1'b0;
        hv_is_on_d   = hv_is_on_q;

        // Grant clears first so a request in the grant cycle re-arms its flag.
        pend_off_d = pend_off_q & ~grant_off;
        pend_cfg_d = pend_cfg_q & ~grant_cfg;
        pend_on_d  = pend_on_q & ~grant_on;
        pend_hv_d  = pend_hv_q;
        if (Req_Cfg) begin
            pend_cfg_d = 1'b1;
            pend_hv_d  = Req_Hv_7Byte;
        end
        if (Req_Off) begin
            pend_off_d = 1'b1;
            pend_on_d  = 1'b0;
        end else if (Req_On) begin
            pend_on_d  = 1'b1;
            pend_off_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_off | grant_cfg | grant_on) begin
                    state_d = ST_SETUP;
                    kind_d  = grant_off ? KIND_OFF : (grant_cfg ? KIND_CFG : KIND_ON);
                end
            end
            ST_SETUP: begin
                if (kind_q == KIND_CFG) begin
                    prep_hv_d = pend_hv_q;
                    exp_cnt_d = 4'd12;
                end else begin
                    flag_start_d = (kind_q == KIND_ON);
                    exp_cnt_d    = 4'd8;
                end
                byte_cnt_d = 4'd0;
                step_d     = 1'b0;
                state_d    = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                step_d = ~step_q;
                if (step_q) state_d = ST_COUNT;
            end
            ST_COUNT: begin
                if (Prep_Out_En) begin
                    byte_cnt_d = byte_cnt_q + 4'd1;
                    if (byte_cnt_d == exp_cnt_q) begin
                        state_d = ST_DRAIN;
                        step_d  = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (step_q && !Tx_Busy) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_CYCLES - 16'd1;
                end else begin
                    step_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 16'd0) begin
                    state_d = ST_IDLE;
                    if (!aborted) begin
                        done_d = 1'b1;
                        if (kind_q != KIND_CFG) hv_is_on_d = (kind_q == KIND_ON);
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef HV_TIMEOUT_EN
        wd_d    = wd_q;
        err_d   = err_q;
        abort_d = abort_q;
        if (Clr_Err) err_d = 1'b0;
        // Preloaded with SETUP plus the two LAUNCH cycles so the limit is measured from SETUP.
        if (state_q == ST_SETUP) begin
            wd_d    = 24'd3;
            abort_d = 1'b0;
        end else if (state_q == ST_COUNT || state_q == ST_DRAIN) begin
            wd_d = wd_q + 24'd1;
            if (wd_q >= TIMEOUT_CYCLES - 24'd1) begin
                err_d     = 1'b1;
                abort_d   = 1'b1;
                state_d   = ST_GAP;
                gap_cnt_d = GAP_CYCLES - 16'd1;
            end
        end
`endif
    end

    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q      <= ST_IDLE;
            kind_q       <= KIND_CFG;
            pend_cfg_q   <= 1'b0;
            pend_on_q    <= 1'b0;
            pend_off_q   <= 1'b0;
            pend_hv_q    <= HV_RESET;
            prep_hv_q    <= HV_RESET;
            flag_start_q <= 1'b0;
            exp_cnt_q    <= 4'd0;
            byte_cnt_q   <= 4'd0;
            step_q       <= 1'b0;
            gap_cnt_q    <= 16'd0;
            done_q       <= 1'b0;
            hv_is_on_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            pend_cfg_q   <= pend_cfg_d;
            pend_on_q    <= pend_on_d;
            pend_off_q   <= pend_off_d;
            pend_hv_q    <= pend_hv_d;
            prep_hv_q    <= prep_hv_d;
            flag_start_q <= flag_start_d;
            exp_cnt_q    <= exp_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            step_q       <= step_d;
            gap_cnt_q    <= gap_cnt_d;
            done_q       <= done_d;
            hv_is_on_q   <= hv_is_on_d;
        end
    end

`ifdef HV_TIMEOUT_EN
    always_ff @(posedge Clk_In or negedge Rst_N) begin
        if (!Rst_N) begin
            wd_q    <= 24'd0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            err_q   <= err_d;
            abort_q <= abort_d;
        end
    end
`endif

    assign Prep_Start_Cfg     = (state_q == ST_LAUNCH) && (kind_q == KIND_CFG);
    assign Prep_Start_Stop_Hv = (state_q == ST_LAUNCH) && (kind_q != KIND_CFG);
    assign Prep_Flag_Start    = flag_start_q;
    assign Prep_Hv_7Byte      = prep_hv_q;
    assign Busy               = !in_idle;
    assign Done               = done_q;
    assign Hv_Is_On           = hv_is_on_q;
endmodule

// File: tb/tb_hv_cmd_scheduler.sv
// Directed bench for hv_cmd_scheduler: launch-order scoreboard, completion timing, watchdog and reset.
module tb_hv_cmd_scheduler;
    localparam logic [15:0] GAP = 16'd8;
    localparam logic [23:0] TMO = 24'd1000;
    localparam logic [1:0]  K_CFG = 2'd0;
    localparam logic [1:0]  K_ON  = 2'd1;
    localparam logic [1:0]  K_OFF = 2'd2;
    localparam logic [55:0] HV0   = 56'h30_30_30_30_30_30_30;

    logic        Clk_In = 1'b0;
    logic        Rst_N = 1'b0;
    logic        Req_Cfg = 1'b0, Req_On = 1'b0, Req_Off = 1'b0, Clr_Err = 1'b0;
    logic [55:0] Req_Hv_7Byte = 56'd0;
    logic        Prep_Out_En = 1'b0, Tx_Busy = 1'b0;
    logic        Prep_Start_Cfg, Prep_Start_Stop_Hv, Prep_Flag_Start;
    logic [55:0] Prep_Hv_7Byte;
    logic        Busy, Done, Err_Timeout, Hv_Is_On;

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    logic start_prev = 1'b0;
    logic [57:0] exp_q[$];

    hv_cmd_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .Clk_In(Clk_In), .Rst_N(Rst_N),
        .Req_Cfg(Req_Cfg), .Req_Hv_7Byte(Req_Hv_7Byte), .Req_On(Req_On), .Req_Off(Req_Off),
        .Clr_Err(Clr_Err),
        .Prep_Start_Cfg(Prep_Start_Cfg), .Prep_Start_Stop_Hv(Prep_Start_Stop_Hv),
        .Prep_Flag_Start(Prep_Flag_Start), .Prep_Hv_7Byte(Prep_Hv_7Byte),
        .Prep_Out_En(Prep_Out_En), .Tx_Busy(Tx_Busy),
        .Busy(Busy), .Done(Done), .Err_Timeout(Err_Timeout), .Hv_Is_On(Hv_Is_On)
    );

    // clock / reset
    always #5 Clk_In = ~Clk_In;
    always @(posedge Clk_In) cyc++;

    initial begin
        #500000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1);
    end

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_hv(input string tag, input logic [55:0] obs, input logic [55:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [57:0] obs, input logic [57:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // scoreboard: every launch edge pops the next expected {kind, payload}
    always @(negedge Clk_In) begin
        logic start_now;
        logic [57:0] obs;
        start_now = Prep_Start_Cfg | Prep_Start_Stop_Hv;
        if (start_now && !start_prev) begin
            start_cnt++;
            check_bit("launch_single_start", Prep_Start_Cfg & Prep_Start_Stop_Hv, 1'b0);
            obs = {Prep_Start_Cfg ? K_CFG : (Prep_Flag_Start ? K_ON : K_OFF),
                   Prep_Start_Cfg ? Prep_Hv_7Byte : 56'd0};
            check_bit("launch_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) check_word("launch_kind_payload", obs, exp_q.pop_front());
        end
        start_prev = start_now;
        if (Done) done_cnt++;
    end

    // driver tasks
    task automatic pulse_req(input logic c, input logic on, input logic off, input logic [55:0] hv);
        Req_Cfg = c; Req_On = on; Req_Off = off; Req_Hv_7Byte = hv;
        @(negedge Clk_In);
        Req_Cfg = 1'b0; Req_On = 1'b0; Req_Off = 1'b0;
        Req_Hv_7Byte = {$urandom, $urandom_range(16777215, 0)};
    endtask

    task automatic wait_launch(input string tag, output int launch_c);
        int guard = 0;
        while (!(Prep_Start_Cfg | Prep_Start_Stop_Hv) && guard < 100) begin
            @(negedge Clk_In);
            guard++;
        end
        check_bit({tag, "_launch_seen"}, guard < 100, 1'b1);
        launch_c = cyc;
    endtask

    task automatic serve_cmd(input int n_bytes, input string tag, output int launch_c, output int done_c);
        int guard;
        int drop_c;
        done_c = -1;
        wait_launch(tag, launch_c);
        repeat (2) @(negedge Clk_In);
        check_bit({tag, "_start_low_in_count"}, Prep_Start_Cfg | Prep_Start_Stop_Hv, 1'b0);
        for (int i = 0; i < n_bytes; i++) begin
            Prep_Out_En = 1'b1;
            Tx_Busy = 1'b1;
            @(negedge Clk_In);
        end
        Prep_Out_En = 1'b0;
        repeat (2) @(negedge Clk_In);
        Tx_Busy = 1'b0;
        drop_c = cyc;
        guard = 0;
        while (!Done && guard < int'(GAP) + 20) begin
            @(negedge Clk_In);
            guard++;
        end
        check_int({tag, "_done_latency"}, cyc - drop_c, int'(GAP) + 1);
        check_bit({tag, "_idle_at_done"}, Busy, 1'b0);
        done_c = cyc;
        @(negedge Clk_In);
        check_bit({tag, "_done_one_cycle"}, Done, 1'b0);
    endtask

    initial begin
        int l1, d1, l2, d2, l3, d3, req_c, base_start, base_done, guard, err_c;
        logic [55:0] pa, pb, pc;

        repeat (3) @(negedge Clk_In);
        check_bit("rst_busy", Busy, 1'b0);
        check_bit("rst_start_cfg", Prep_Start_Cfg, 1'b0);
        check_bit("rst_start_hv", Prep_Start_Stop_Hv, 1'b0);
        check_bit("rst_flag", Prep_Flag_Start, 1'b0);
        check_bit("rst_done", Done, 1'b0);
        check_bit("rst_err", Err_Timeout, 1'b0);
        check_bit("rst_hv_on", Hv_Is_On, 1'b0);
        check_hv("rst_prep_hv", Prep_Hv_7Byte, HV0);
        Rst_N = 1'b1;
        repeat (2) @(negedge Clk_In);

        // config frame "1234567"
        base_start = start_cnt;
        base_done = done_cnt;
        exp_q.push_back({K_CFG, 56'h31_32_33_34_35_36_37});
        req_c = cyc;
        pulse_req(1'b1, 1'b0, 1'b0, 56'h31_32_33_34_35_36_37);
        serve_cmd(12, "cfg1", l1, d1);
        check_int("cfg1_launch_latency", l1 - req_c, 3);
        check_hv("cfg1_payload", Prep_Hv_7Byte, 56'h31_32_33_34_35_36_37);
        check_bit("cfg1_hv_is_on", Hv_Is_On, 1'b0);
        check_int("cfg1_one_edge", start_cnt - base_start, 1);
        check_int("cfg1_one_done", done_cnt - base_done, 1);

        // on, then off requested while busy
        base_done = done_cnt;
        exp_q.push_back({K_ON, 56'd0});
        pulse_req(1'b0, 1'b1, 1'b0, 56'd0);
        fork
            serve_cmd(8, "on2", l1, d1);
            begin
                repeat (4) @(negedge Clk_In);
                exp_q.push_back({K_OFF, 56'd0});
                pulse_req(1'b0, 1'b0, 1'b1, 56'd0);
            end
        join
        check_bit("on2_hv_is_on", Hv_Is_On, 1'b1);
        serve_cmd(8, "off2", l2, d2);
        check_int("off2_after_gap", l2 - d1, 2);
        check_bit("off2_hv_is_on", Hv_Is_On, 1'b0);
        check_bit("off2_flag", Prep_Flag_Start, 1'b0);
        check_int("on_off_two_dones", done_cnt - base_done, 2);

        // on and off in the same cycle: off wins
        base_start = start_cnt;
        exp_q.push_back({K_OFF, 56'd0});
        pulse_req(1'b0, 1'b1, 1'b1, 56'd0);
        serve_cmd(8, "onoff3", l1, d1);
        repeat (20) @(negedge Clk_In);
        check_int("onoff3_one_edge", start_cnt - base_start, 1);
        check_int("onoff3_queue_empty", exp_q.size(), 0);

        // off + cfg together, on one cycle later: priority order off, cfg, on
        pa = {$urandom, $urandom_range(16777215, 0)};
        exp_q.push_back({K_OFF, 56'd0});
        exp_q.push_back({K_CFG, pa});
        pulse_req(1'b1, 1'b0, 1'b1, pa);
        exp_q.push_back({K_ON, 56'd0});
        pulse_req(1'b0, 1'b1, 1'b0, 56'd0);
        serve_cmd(8, "prio_off", l1, d1);
        serve_cmd(12, "prio_cfg", l2, d2);
        serve_cmd(8, "prio_on", l3, d3);
        check_int("prio_cfg_after_gap", l2 - d1, 2);
        check_int("prio_on_after_gap", l3 - d2, 2);
        check_hv("prio_payload", Prep_Hv_7Byte, pa);
        check_bit("prio_hv_is_on", Hv_Is_On, 1'b1);

        // last payload and last on/off request win while busy
        pa = {$urandom, $urandom_range(16777215, 0)};
        pb = {$urandom, $urandom_range(16777215, 0)};
        exp_q.push_back({K_OFF, 56'd0});
        pulse_req(1'b0, 1'b0, 1'b1, 56'd0);
        fork
            serve_cmd(8, "last_off", l1, d1);
            begin
                repeat (2) @(negedge Clk_In);
                pulse_req(1'b1, 1'b0, 1'b0, pa);
                pulse_req(1'b1, 1'b0, 1'b0, pb);
                pulse_req(1'b0, 1'b0, 1'b1, 56'd0);
                pulse_req(1'b0, 1'b1, 1'b0, 56'd0);
                exp_q.push_back({K_CFG, pb});
                exp_q.push_back({K_ON, 56'd0});
            end
        join
        check_bit("last_off_hv_is_on", Hv_Is_On, 1'b0);
        serve_cmd(12, "last_cfg", l2, d2);
        serve_cmd(8, "last_on", l3, d3);
        check_hv("last_payload", Prep_Hv_7Byte, pb);
        check_bit("last_hv_is_on", Hv_Is_On, 1'b1);

`ifdef HV_TIMEOUT_EN
        // stall after 5 of 12 bytes
        pc = {$urandom, $urandom_range(16777215, 0)};
        exp_q.push_back({K_CFG, pc});
        pulse_req(1'b1, 1'b0, 1'b0, pc);
        base_done = done_cnt;
        wait_launch("tmo", l1);
        repeat (2) @(negedge Clk_In);
        for (int i = 0; i < 5; i++) begin
            Prep_Out_En = 1'b1;
            Tx_Busy = 1'b1;
            @(negedge Clk_In);
        end
        Prep_Out_En = 1'b0;
        Tx_Busy = 1'b0;
        guard = 0;
        while (!Err_Timeout && guard < 1200) begin
            @(negedge Clk_In);
            guard++;
        end
        err_c = cyc;
        check_int("tmo_latency", err_c - l1, int'(TMO) - 1);
        repeat (7) @(negedge Clk_In);
        check_bit("tmo_busy_in_gap", Busy, 1'b1);
        @(negedge Clk_In);
        check_bit("tmo_idle_after_gap", Busy, 1'b0);
        check_int("tmo_no_done", done_cnt - base_done, 0);
        check_bit("tmo_hv_unchanged", Hv_Is_On, 1'b1);
        check_bit("tmo_sticky", Err_Timeout, 1'b1);
        Clr_Err = 1'b1;
        @(negedge Clk_In);
        Clr_Err = 1'b0;
        check_bit("tmo_cleared", Err_Timeout, 1'b0);
`else
        pc = 56'd0;
        err_c = 0;
        Clr_Err = 1'b1;
        @(negedge Clk_In);
        Clr_Err = 1'b0;
        check_bit("no_watchdog_err_low", Err_Timeout, 1'b0);
`endif

        // reset in COUNT with a request pending
        pc = {$urandom, $urandom_range(16777215, 0)};
        exp_q.push_back({K_CFG, pc});
        pulse_req(1'b1, 1'b0, 1'b0, pc);
        wait_launch("rst", l1);
        repeat (2) @(negedge Clk_In);
        for (int i = 0; i < 3; i++) begin
            Prep_Out_En = 1'b1;
            Tx_Busy = 1'b1;
            @(negedge Clk_In);
        end
        pulse_req(1'b0, 1'b1, 1'b0, 56'd0);
        Rst_N = 1'b0;
        #1;
        check_bit("midrst_busy", Busy, 1'b0);
        check_bit("midrst_start_cfg", Prep_Start_Cfg, 1'b0);
        check_bit("midrst_start_hv", Prep_Start_Stop_Hv, 1'b0);
        check_bit("midrst_hv_on", Hv_Is_On, 1'b0);
        check_bit("midrst_flag", Prep_Flag_Start, 1'b0);
        check_hv("midrst_prep_hv", Prep_Hv_7Byte, HV0);
        exp_q.delete();
        Prep_Out_En = 1'b0;
        Tx_Busy = 1'b0;
        base_start = start_cnt;
        repeat (3) @(negedge Clk_In);
        Rst_N = 1'b1;
        repeat (20) @(negedge Clk_In);
        check_int("postrst_no_launch", start_cnt - base_start, 0);
        check_bit("postrst_idle", Busy, 1'b0);

        check_int("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
